// File: rtl/i2c_target_wr_rx.sv
// I2C target write receiver: oversamples SCL/SDA, detects START/STOP, matches the
// 7-bit address, ACKs through sda_t and hands each received byte to fabric logic.
module i2c_target_wr_rx #(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       en,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_t,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       start_det,
  output logic       stop_det,
  output logic       addr_match,
  output logic       busy,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_DATA     = 3'd3,
    S_DATA_ACK = 3'd4,
    S_IGNORE   = 3'd5
  } state_t;

  localparam logic [3:0] FILT_MAX = 4'(FILTER_LEN);

  // Index 0 carries SCL, index 1 carries SDA through the input path.
  logic [1:0]      w_pins;
  logic [1:0]      r_sync1;
  logic [1:0]      r_sync2;
  logic [1:0]      r_filt;
  logic [1:0]      r_filt_d;
  logic [1:0][3:0] r_fcnt;

  assign w_pins = {sda_i, scl_i};

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1  <= 2'b11;
      r_sync2  <= 2'b11;
      r_filt   <= 2'b11;
      r_filt_d <= 2'b11;
      r_fcnt   <= '0;
    end else begin
      r_sync1  <= w_pins;
      r_sync2  <= r_sync1;
      r_filt_d <= r_filt;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] + 4'd1 >= FILT_MAX) begin
          r_filt[i] <= r_sync2[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 4'd1;
        end
      end
    end
  end

  logic w_scl_f;
  logic w_sda_f;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  assign w_scl_f    = r_filt[0];
  assign w_sda_f    = r_filt[1];
  assign w_scl_rise = w_scl_f & ~r_filt_d[0];
  assign w_scl_fall = ~w_scl_f & r_filt_d[0];
  assign w_start    = w_scl_f & r_filt_d[1] & ~w_sda_f;
  assign w_stop     = w_scl_f & ~r_filt_d[1] & w_sda_f;

  state_t     r_state, w_state;
  logic [3:0] r_bit_cnt, w_bit_cnt;
  logic [7:0] r_shift, w_shift;
  logic [7:0] w_shift_in;
  logic       r_sda_t, w_sda_t;
  logic       r_addr_match, w_addr_match;
  logic       r_busy, w_busy;
  logic [7:0] r_rx_data, w_rx_data;
  logic       r_rx_valid, w_rx_valid;
  logic       r_start_det, w_start_det;
  logic       r_stop_det, w_stop_det;
  logic       r_ack_flag, w_ack_flag;

  assign w_shift_in = {r_shift[6:0], w_sda_f};

  // Handshake: rx_valid is a single-cycle strobe with rx_data already loaded;
  // rx_ready is sampled only in that cycle and decides ACK (1) or NACK (0).
  always_comb begin
    w_state      = r_state;
    w_bit_cnt    = r_bit_cnt;
    w_shift      = r_shift;
    w_sda_t      = r_sda_t;
    w_addr_match = r_addr_match;
    w_busy       = r_busy;
    w_rx_data    = r_rx_data;
    w_rx_valid   = 1'b0;
    w_start_det  = 1'b0;
    w_stop_det   = 1'b0;
    w_ack_flag   = r_rx_valid ? rx_ready : r_ack_flag;

    if (w_stop) begin
      w_state      = S_IDLE;
      w_bit_cnt    = '0;
      w_sda_t      = 1'b1;
      w_addr_match = 1'b0;
      w_busy       = 1'b0;
      w_stop_det   = 1'b1;
    end else if (w_start) begin
      w_state      = S_ADDR;
      w_bit_cnt    = '0;
      w_sda_t      = 1'b1;
      w_addr_match = 1'b0;
      w_busy       = 1'b1;
      w_start_det  = 1'b1;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise && r_bit_cnt != 4'd8) begin
            w_shift   = w_shift_in;
            w_bit_cnt = r_bit_cnt + 4'd1;
          end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
            if (r_shift[7:1] == TARGET_ADDR && !r_shift[0]) begin
              w_state      = S_ADDR_ACK;
              w_sda_t      = 1'b0;
              w_addr_match = 1'b1;
            end else begin
              w_state = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK, S_DATA_ACK: begin
          if (w_scl_fall) begin
            w_state   = S_DATA;
            w_sda_t   = 1'b1;
            w_bit_cnt = '0;
          end
        end
        S_DATA: begin
          if (w_scl_rise && r_bit_cnt != 4'd8) begin
            w_shift   = w_shift_in;
            w_bit_cnt = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              w_rx_data  = w_shift_in;
              w_rx_valid = 1'b1;
            end
          end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
            if (w_ack_flag) begin
              w_state = S_DATA_ACK;
              w_sda_t = 1'b0;
            end else begin
              w_state = S_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end

    if (!en) begin
      w_state      = S_IDLE;
      w_bit_cnt    = '0;
      w_sda_t      = 1'b1;
      w_addr_match = 1'b0;
      w_busy       = 1'b0;
      w_rx_valid   = 1'b0;
      w_start_det  = 1'b0;
      w_stop_det   = 1'b0;
      w_ack_flag   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_sda_t      <= 1'b1;
      r_addr_match <= 1'b0;
      r_busy       <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_start_det  <= 1'b0;
      r_stop_det   <= 1'b0;
      r_ack_flag   <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_bit_cnt    <= w_bit_cnt;
      r_shift      <= w_shift;
      r_sda_t      <= w_sda_t;
      r_addr_match <= w_addr_match;
      r_busy       <= w_busy;
      r_rx_data    <= w_rx_data;
      r_rx_valid   <= w_rx_valid;
      r_start_det  <= w_start_det;
      r_stop_det   <= w_stop_det;
      r_ack_flag   <= w_ack_flag;
    end
  end

  assign sda_t       = r_sda_t;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign start_det   = r_start_det;
  assign stop_det    = r_stop_det;
  assign addr_match  = r_addr_match;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_i2c_target_wr_rx.sv
// Bench for i2c_target_wr_rx: an I2C controller model drives 64-cycle SCL bit
// periods; expected bytes, ACK bits and START/STOP counts come from transaction rules.
module tb_i2c_target_wr_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       en = 1'b1;
  logic       ctl_scl = 1'b1;
  logic       ctl_sda = 1'b1;
  logic       rx_ready = 1'b0;
  logic       sda_line;
  logic       sda_t;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       start_det;
  logic       stop_det;
  logic       addr_match;
  logic       busy;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_pass = 0;
  int m_starts = 0;
  int m_stops = 0;
  int seen_starts = 0;
  int seen_stops = 0;
  logic       m_in_ack = 1'b0;
  logic [7:0] m_last_rx = 8'h00;
  logic [7:0] exp_q[$];

  localparam logic [6:0] MODEL_ADDR = 7'h50;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  assign sda_line = ctl_sda & sda_t;

  // clock / reset
  always #3 CLK = ~CLK;

  i2c_target_wr_rx #(.TARGET_ADDR(7'h50), .FILTER_LEN(4)) dut (
    .CLK(CLK), .RST(RST), .en(en), .scl_i(ctl_scl), .sda_i(sda_line),
    .sda_t(sda_t), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .start_det(start_det), .stop_det(stop_det), .addr_match(addr_match),
    .busy(busy), .o_dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // scoreboard / compare process
  always @(negedge CLK) begin
    if (!RST) begin
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          check("rx_valid_unexpected", rx_valid, 1'b0);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          m_last_rx = e;
          check("rx_data", rx_data, e);
        end
      end
      if (start_det) seen_starts++;
      if (stop_det) seen_stops++;
      if (ctl_scl && !m_in_ack) check("sda_released_scl_high", sda_t, 1'b1);
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_start();
    if (!ctl_scl) begin
      ctl_sda = 1'b1; cyc(16);
      ctl_scl = 1'b1; cyc(16);
    end
    ctl_sda = 1'b0; m_starts++; cyc(32);
    ctl_scl = 1'b0; cyc(16);
  endtask

  task automatic send_bit(input logic b);
    ctl_sda = b; cyc(16);
    ctl_scl = 1'b1; cyc(32);
    ctl_scl = 1'b0; cyc(16);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic ack_bit(output logic a);
    ctl_sda = 1'b1; cyc(16);
    ctl_scl = 1'b1; m_in_ack = 1'b1; cyc(16);
    a = sda_line; cyc(16);
    ctl_scl = 1'b0; m_in_ack = 1'b0; cyc(16);
  endtask

  task automatic do_stop();
    ctl_sda = 1'b0; cyc(16);
    ctl_scl = 1'b1; cyc(16);
    ctl_sda = 1'b1; m_stops++; cyc(32);
  endtask

  // One controller write: address byte then n data bytes; rdy[i] is the sink's
  // readiness for byte i. A target ACKs the address only for MODEL_ADDR with W,
  // and keeps delivering/ACKing bytes only while every previous byte was ACKed.
  task automatic xfer(input logic [7:0] abyte, input int n, input logic [31:0] d,
                      input logic [3:0] rdy, input bit stop);
    logic a;
    bit deliver;
    deliver = (abyte[7:1] == MODEL_ADDR) && !abyte[0];
    do_start();
    send_byte(abyte);
    ack_bit(a);
    check("addr_ack_n", a, !deliver);
    check("addr_match", addr_match, deliver);
    check("busy_mid", busy, 1'b1);
    for (int i = 0; i < n; i++) begin
      rx_ready = rdy[i];
      if (deliver) exp_q.push_back(d[8*i +: 8]);
      send_byte(d[8*i +: 8]);
      ack_bit(a);
      deliver = deliver && rdy[i];
      check("data_ack_n", a, !deliver);
    end
    if (stop) begin
      do_stop();
      check("busy_after_stop", busy, 1'b0);
      check("addr_match_after_stop", addr_match, 1'b0);
      check("exp_q_drained", exp_q.size(), 0);
      check("start_count", seen_starts, m_starts);
      check("stop_count", seen_stops, m_stops);
    end
  endtask

  initial begin
    logic [7:0]  abyte;
    logic [31:0] d;
    logic [3:0]  rdy;
    int          n;
    bit          stp;

    cyc(5);
    check("rst_sda_t", sda_t, 1'b1);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_start_det", start_det, 1'b0);
    check("rst_stop_det", stop_det, 1'b0);
    check("rst_addr_match", addr_match, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    RST = 1'b0;
    cyc(10);

    // basic write of 0x3C to 0x50
    xfer(8'hA0, 1, 32'h0000003C, 4'b0001, 1'b1);
    check("lit_rx_3c", rx_data, 8'h3C);
    check("lit_one_start", seen_starts, 1);
    check("lit_one_stop", seen_stops, 1);

    // wrong address
    xfer(8'hA2, 1, 32'h00000099, 4'b0001, 1'b1);
    check("lit_rx_still_3c", rx_data, 8'h3C);

    // read request is refused
    xfer(8'hA1, 0, 32'h0, 4'b0000, 1'b0);
    check("read_ignore_state", dbg_state, ST_IGNORE);
    do_stop();
    check("read_busy_end", busy, 1'b0);

    // back-pressure on the second byte
    xfer(8'hA0, 3, 32'h00332211, 4'b0101, 1'b1);
    check("lit_rx_22", rx_data, 8'h22);

    // repeated START after a partial data byte
    xfer(8'hA0, 0, 32'h0, 4'b0000, 1'b0);
    rx_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    xfer(8'hA0, 1, 32'h0000005A, 4'b0001, 1'b1);
    check("lit_rx_5a", rx_data, 8'h5A);

    // reset while the address ACK is driven
    do_start();
    send_byte(8'hA0);
    ctl_sda = 1'b1; cyc(16);
    ctl_scl = 1'b1; m_in_ack = 1'b1; cyc(8);
    check("ack_driven_before_rst", sda_t, 1'b0);
    RST = 1'b1; cyc(1);
    check("midrst_sda_t", sda_t, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_addr_match", addr_match, 1'b0);
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_state", dbg_state, ST_IDLE);
    RST = 1'b0; m_last_rx = 8'h00; cyc(8);
    ctl_scl = 1'b0; m_in_ack = 1'b0; cyc(16);
    do_stop();
    xfer(8'hA0, 1, 32'h00000077, 4'b0001, 1'b1);
    check("lit_rx_77", rx_data, 8'h77);

    // disable while the address ACK is driven
    do_start();
    send_byte(8'hA0);
    ctl_sda = 1'b1; cyc(16);
    ctl_scl = 1'b1; m_in_ack = 1'b1; cyc(8);
    en = 1'b0; cyc(1);
    check("en0_sda_t", sda_t, 1'b1);
    check("en0_busy", busy, 1'b0);
    check("en0_addr_match", addr_match, 1'b0);
    check("en0_state", dbg_state, ST_IDLE);
    check("en0_rx_hold", rx_data, m_last_rx);
    cyc(12);
    en = 1'b1; cyc(4);
    ctl_scl = 1'b0; m_in_ack = 1'b0; cyc(16);
    do_stop();
    check("en_start_count", seen_starts, m_starts);
    check("en_stop_count", seen_stops, m_stops);

    // SDA glitches while SCL idles high
    cyc(10);
    ctl_sda = 1'b0; cyc(3);
    ctl_sda = 1'b1; cyc(20);
    check("glitch3_starts", seen_starts, m_starts);
    check("glitch3_busy", busy, 1'b0);
    ctl_sda = 1'b0; cyc(5);
    ctl_sda = 1'b1; m_starts++; m_stops++; cyc(20);
    check("glitch5_starts", seen_starts, m_starts);
    check("glitch5_stops", seen_stops, m_stops);
    check("glitch5_busy", busy, 1'b0);

    // randomized transactions
    for (int t = 0; t < 12; t++) begin
      abyte = ($urandom_range(0, 9) < 7) ? 8'hA0 : 8'($urandom_range(0, 255));
      n = int'($urandom_range(1, 4));
      d = $urandom;
      for (int i = 0; i < 4; i++) rdy[i] = ($urandom_range(0, 4) != 0);
      stp = (t == 11) || ($urandom_range(0, 4) != 0);
      xfer(abyte, n, d, rdy, stp);
    end

    cyc(10);
    check("final_starts", seen_starts, m_starts);
    check("final_stops", seen_stops, m_stops);
    check("final_exp_q_empty", exp_q.size(), 0);
    check("final_rx_data", rx_data, m_last_rx);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_target_wr_rx.md
Name: i2c_target_wr_rx

Overview:
I2C target-side (responder) write receiver, the far end of the 100 kHz controller SCL generator. It runs on the 156.25 MHz fabric clock and oversamples the open-drain SCL/SDA pins. It detects START and STOP conditions, receives and compares the 7-bit address, and ACKs by pulling SDA low through the tristate control. Each received write byte is presented to fabric logic with a one-cycle valid strobe and a ready handshake. Read requests (R/W=1) are NACKed; there is no transmit path.

Parameters:
TARGET_ADDR, 7'h50, 7-bit address this target responds to
FILTER_LEN, 4, consecutive identical synchronized samples required before a filtered SCL/SDA level changes (1..15)

Ports:
CLK  in  1  fabric clock, 156.25 MHz
RST  in  1  synchronous, active-high reset
en  in  1  block enable; 0 forces idle and releases SDA
scl_i  in  1  raw SCL pin input (asynchronous)
sda_i  in  1  raw SDA pin input (asynchronous)
sda_t  out  1  SDA tristate control; 1 = release (Z), 0 = drive low
rx_data  out  8  last received data byte, MSB first on the wire
rx_valid  out  1  one-cycle strobe: rx_data holds a new byte
rx_ready  in  1  sink can accept the byte; sampled in the rx_valid cycle
start_det  out  1  one-cycle pulse on START or repeated START
stop_det  out  1  one-cycle pulse on STOP
addr_match  out  1  high from the address-ACK cycle until the next START or STOP
busy  out  1  high between START and STOP, whether or not the address matches

Behaviour:
- Reset (RST=1 at a CLK edge): sda_t=1; rx_data=0; rx_valid, start_det, stop_det, addr_match and busy = 0; FSM=IDLE; synchronizers and filters preset to 1 (bus idle).
- Reset mid-transfer: SDA is released on the first CLK edge with RST high, even if it was mid-ACK.
- en=0: same effect as reset on FSM, sda_t and flags; rx_data holds its value.
- Input path: 2-FF synchronizer, then a filter that updates only after FILTER_LEN equal samples. Pin-to-filtered latency is 2+FILTER_LEN cycles (6 at default).
- Edge detection uses filtered signals scl_f and sda_f, delayed by one cycle.
  - START: sda_f falls while scl_f=1.
  - STOP: sda_f rises while scl_f=1.
  - START/STOP are evaluated before bit sampling in the same cycle.
  - start_det or stop_det pulses in the cycle the condition is detected.
- Bits are sampled on the scl_f rising edge. SDA is driven or released on the scl_f falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
  - IDLE: START -> ADDR, busy=1, bit count=0.
  - ADDR: shift 8 bits.
    - On the falling edge after the 8th bit: if addr[7:1]==TARGET_ADDR and R/W=0, then addr_match=1, sda_t=0 -> ADDR_ACK.
    - Otherwise sda_t stays 1 -> IGNORE.
  - ADDR_ACK: release sda_t at the next scl_f falling edge -> DATA.
  - DATA: shift 8 bits. The 8th-bit rising edge loads rx_data and pulses rx_valid in the same cycle.
    - If rx_ready=1 in that cycle, set an ACK flag; at the next scl_f falling edge sda_t=0 -> DATA_ACK.
    - If rx_ready=0, the byte counts as delivered but is NACKed: sda_t stays 1 -> IGNORE.
  - DATA_ACK: release sda_t at the next scl_f falling edge -> DATA (next byte).
  - IGNORE: hold sda_t=1 and wait for START or STOP.
- STOP in any state -> IDLE, with sda_t=1, busy=0, addr_match=0.
- START in any non-IDLE state (repeated START) -> ADDR, with bit count cleared, sda_t=1, addr_match=0.
- sda_t is driven low only in ADDR_ACK and DATA_ACK. It is never low while scl_f=1 except during the ACK bit's high phase.
- A partial byte (<8 bits) interrupted by START/STOP is discarded with no rx_valid.
- No clock stretching: SCL is never driven.

Test Plan:
- Bench setup: SCL period 64 CLK cycles, FILTER_LEN=4.
- Write to 0x50 (byte 0xA0), data 0x3C, STOP, rx_ready=1 -> start_det pulse; sda_t=0 for the full address ACK bit; rx_valid once with rx_data=0x3C; data ACK low; stop_det pulse; busy returns to 0.
- Address 0x51 write -> no ACK (sda_t stays 1 throughout), addr_match=0, no rx_valid; busy=1 until STOP.
- Address 0x50 read (byte 0xA1) -> NACK, FSM in IGNORE, no rx_valid.
- Write 0x50, bytes 0x11, 0x22, 0x33, with rx_ready=0 at the 0x22 strobe -> rx_valid for 0x11 (ACK) and 0x22 (NACK); no strobe for 0x33 (ignored).
- Repeated START after 4 bits of a data byte, then a new 0x50 write with 0x5A -> partial byte dropped; second start_det; rx_data=0x5A.
- RST asserted during the address ACK (sda_t=0) -> sda_t=1 on the next CLK edge; all flags 0; a subsequent full write of 0x77 is received correctly.
- Glitch test: a 3-cycle SDA low pulse while SCL is high -> no start_det; a 5-cycle pulse -> start_det.
